// File: rtl/ram_sp_sync_read.sv
// ram_sp_sync_read: single-port RAM with synchronous write and registered-address read.
// The address is captured on every rising edge. data_out is a combinational read of the
// word at the captured address. Because of this, a write followed by a read of the same
// address shows the new data straight after the write edge (write-first).
// Optional build macro: MEM_CLEAR_ON_RESET_EN. When it is defined, a reset edge also
// zeroes every memory word.
`timescale 1ns/1ps
module ram_sp_sync_read #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write_en,
    output logic [DATA_WIDTH-1:0] data_out
);

    // The address decode assumes a full power-of-two array with no out-of-range slots.
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("ram_sp_sync_read: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic                  w_wr;

    // A write is accepted only outside reset. During reset, data_in and address are dropped.
    assign w_wr = rst_n & write_en;

    // Address register: it loads on every cycle, including write cycles, so reads are write-first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr_q <= '0;
        end else begin
            r_addr_q <= address;
        end
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    // Memory array: a reset edge clears every word. Otherwise the addressed word is written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[address] <= data_in;
        end
    end
`else
    // Memory array: reset does not touch the contents, so data from before reset survives it.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[address] <= data_in;
        end
    end
`endif

    // Unregistered read port. Address changes between edges cannot reach the output.
    assign data_out = r_mem[r_addr_q];

endmodule

// File: tb/tb_ram_sp_sync_read.sv
// tb_ram_sp_sync_read: scoreboard bench for ram_sp_sync_read.
// The stimulus process keeps a word-array model of the RAM and queues the expected
// data_out value. The checker pops from the queue 1ns after each clock edge.
`timescale 1ns/1ps
module tb_ram_sp_sync_read;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef MEM_CLEAR_ON_RESET_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic [AW-1:0] address;
    logic          write_en;
    logic [DW-1:0] data_out;

    always #5 clk = ~clk;

    ram_sp_sync_read #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .address  (address),
        .write_en (write_en),
        .data_out (data_out)
    );

    // Reference model: an array of words plus a known-flag, because power-up contents are undefined.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    int            m_aq = 0;

    logic [DW-1:0] q_exp [$];
    string         q_name [$];
    int            errors = 0;
    int            checks = 0;

    task automatic push(input logic [DW-1:0] v, input string nm);
        q_exp.push_back(v);
        q_name.push_back(nm);
    endtask

    // Each call performs one clock cycle of access.
    // Inputs are driven at the falling edge, and the model advances at the rising edge.
    task automatic step(input bit rst, input bit we, input int addr, input logic [DW-1:0] din,
                        input string nm);
        @(negedge clk);
        rst_n    = !rst;
        write_en = we;
        address  = addr[AW-1:0];
        data_in  = din;
        // A new address presented mid-cycle must not disturb the current read.
        if (m_known[m_aq]) push(m_mem[m_aq], {nm, "/hold"});
        @(posedge clk);
        if (rst) begin
            m_aq = 0;
            if (CLR) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i]   = '0;
                    m_known[i] = 1'b1;
                end
            end
        end else begin
            m_aq = addr % DEPTH;
            if (we) begin
                m_mem[m_aq]   = din;
                m_known[m_aq] = 1'b1;
            end
        end
        if (m_known[m_aq]) push(m_mem[m_aq], nm);
    endtask

    // Checker: after every clock transition, compare data_out against all pending expectations.
    initial begin : monitor
        logic [DW-1:0] e;
        string         n;
        forever begin
            @(clk);
            #1;
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n = q_name.pop_front();
                checks++;
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL %s: data_out=%h expected=%h", n, data_out, e);
                end
            end
        end
    end

    initial begin : stim
        logic [DW-1:0] d;
        int            a;
        rst_n    = 1'b0;
        write_en = 1'b0;
        address  = '0;
        data_in  = '0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

        // Reset with a write pending. The write must be discarded.
        step(1, 1, 5, 8'hFF, "reset0");
        step(1, 0, 0, 8'h00, "reset1");

        // Write/readback sweep. data_in is randomised on reads to confirm it is ignored.
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'($urandom);
            step(0, 1, i, d, $sformatf("sweep_wr%0d", i));
            step(0, 0, i, DW'($urandom), $sformatf("sweep_rd%0d", i));
        end

        // Address 16 wraps to 0.
        step(0, 1, 16, 8'h5A, "wrap_wr");
        step(0, 0, 5, 8'h00, "other");
        step(0, 0, 0, 8'h00, "wrap_rd");

        // Write-first: the new data must be visible right after the write edge.
        step(0, 0, 3, 8'h00, "wf_pre");
        step(0, 1, 3, 8'hA5, "wf_wr");
        step(0, 0, 3, 8'h00, "wf_rd");

        // Address hold: change from 7 to 8. The output changes only after the next edge.
        step(0, 0, 7, 8'h00, "hold_rd7");
        step(0, 0, 8, 8'h00, "hold_rd8");

        // Reset test.
        step(0, 1, 2, 8'h11, "rst_wr2");
        step(1, 1, 5, 8'hFF, "rst_edge");
        step(0, 0, 2, 8'h00, "rst_rd2");
        step(0, 0, 5, 8'h00, "rst_rd5");

        // Back-to-back alternating writes.
        step(0, 1, 1, 8'h01, "b2b_wr1");
        step(0, 1, 2, 8'h02, "b2b_wr2");
        step(0, 1, 1, 8'h01, "b2b_wr1b");
        step(0, 1, 2, 8'h02, "b2b_wr2b");
        step(0, 0, 1, 8'h00, "b2b_rd1");
        step(0, 0, 2, 8'h00, "b2b_rd2");

        // Random traffic with occasional resets.
        for (int k = 0; k < 300; k++) begin
            a = int'($urandom_range(0, 16));
            step($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, a, DW'($urandom),
                 $sformatf("rand%0d", k));
        end

        step(0, 0, 0, 8'h00, "tail");
        @(negedge clk);
        @(negedge clk);
        if (q_exp.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: pending=%0d expected=0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
